// File: rtl/sm_sub_serial.sv
// Bit-serial sign-magnitude subtractor: res = opA - opB, one magnitude bit per clock, LSB first.
// Subtraction is handled as addition of -opB; unlike signs become a compare/swap plus serial borrow.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | pick ADD/SUB mode, order magnitudes, clear carry and counter
// CALC  | one magnitude bit per clock, n-1 clocks
// DONE  | res/ovf just loaded, done pulse; start accepted here too
module sm_sub_serial #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] opA,
    input  logic [n-1:0] opB,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] res,
    output logic         ovf
);

    localparam int MW = n - 1;
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t state, state_nx;

    logic [MW-1:0] mag_a, mag_b;
    logic          sign_a, sign_b;
    logic [MW-1:0] sh_x, sh_y, acc;
    logic          mode_sub, res_sign, cy;
    logic [CW-1:0] cnt;

    logic          accept, last_bit, ld_sub, ld_swap;
    logic          bit_x, bit_y, sum_bit, cy_nx;
    logic [MW-1:0] mag_fin;

    assign busy   = (state == LOAD) || (state == CALC);
    assign done   = (state == DONE);
    assign accept = start && ((state == IDLE) || (state == DONE));

    // Operand ordering decided in LOAD from the captured values.
    assign ld_sub  = sign_a ^ sign_b;
    assign ld_swap = ld_sub && (mag_b > mag_a);

    assign bit_x    = sh_x[0];
    assign bit_y    = sh_y[0];
    assign sum_bit  = bit_x ^ bit_y ^ cy;
    assign last_bit = (state == CALC) && (cnt == CW'(n - 2));
    assign mag_fin  = {sum_bit, acc[MW-1:1]};

    always_comb begin
        cy_nx = 1'b0;
        if (mode_sub)
            cy_nx = (~bit_x & bit_y) | (~bit_x & cy) | (bit_y & cy);
        else
            cy_nx = (bit_x & bit_y) | (bit_x & cy) | (bit_y & cy);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = CALC;
            CALC:    if (last_bit) state_nx = DONE;
            DONE:    state_nx = accept ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a    <= '0;
            mag_b    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            sh_x     <= '0;
            sh_y     <= '0;
            acc      <= '0;
            mode_sub <= 1'b0;
            res_sign <= 1'b0;
            cy       <= 1'b0;
            cnt      <= '0;
            res      <= '0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                mag_a  <= opA[MW-1:0];
                sign_a <= opA[n-1];
                mag_b  <= opB[MW-1:0];
                sign_b <= ~opB[n-1];
            end
            if (state == LOAD) begin
                sh_x     <= ld_swap ? mag_b : mag_a;
                sh_y     <= ld_swap ? mag_a : mag_b;
                res_sign <= ld_swap ? sign_b : sign_a;
                mode_sub <= ld_sub;
                cy       <= 1'b0;
                cnt      <= '0;
                acc      <= '0;
            end
            if (state == CALC) begin
                sh_x <= sh_x >> 1;
                sh_y <= sh_y >> 1;
                acc  <= mag_fin;
                cy   <= cy_nx;
                cnt  <= cnt + 1'b1;
                if (last_bit) begin
                    // zero magnitude never carries a minus sign
                    res <= {res_sign & (|mag_fin), mag_fin};
                    ovf <= ~mode_sub & cy_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_sub_serial.sv
// Directed bench for sm_sub_serial (n = 8): hand-computed differences, timing and handshake corners.
module tb_sm_sub_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] opA = '0;
    logic [7:0] opB = '0;
    logic       busy, done, ovf;
    logic [7:0] res;

    int checks = 0;
    int errors = 0;

    sm_sub_serial #(.n(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .opA  (opA),
        .opB  (opB),
        .busy (busy),
        .done (done),
        .res  (res),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for done after the start edge; returns clocks counted (0 if never seen).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic eo);
        int lat;
        @(negedge clk);
        opA = a; opB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done(lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_res"}, res, er);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ndone;
        logic [7:0] first_res;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", res, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk); rst = 1'b0;

        run_op("p5m3",   8'h05, 8'h03, 8'h02, 1'b0);
        run_op("p3m5",   8'h03, 8'h05, 8'h82, 1'b0);
        run_op("n5m3",   8'h85, 8'h03, 8'h88, 1'b0);
        run_op("ovf100", 8'h64, 8'hE4, 8'h48, 1'b1);
        run_op("eq",     8'h05, 8'h05, 8'h00, 1'b0);
        run_op("negz",   8'h80, 8'h00, 8'h00, 1'b0);
        run_op("n3mn5",  8'h83, 8'h85, 8'h02, 1'b0);
        run_op("ovfneg", 8'hFF, 8'h7F, 8'hFE, 1'b1);

        // start during the DONE cycle: accepted, old result held until new done
        run_op("pre", 8'h05, 8'h03, 8'h02, 1'b0);
        @(negedge clk);
        opA = 8'h03; opB = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("dstart_busy", busy, 1);
        check("dstart_done", done, 0);
        check("dstart_hold", res, 8'h02);
        wait_done(lat);
        check("dstart_lat", lat, 8);
        check("dstart_res", res, 8'h82);

        // start pulsed again in the 3rd busy cycle is ignored
        @(negedge clk);
        opA = 8'h05; opB = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        opA = 8'h7F; opB = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opA = 8'h11; opB = 8'h22;
        ndone = 0;
        first_res = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                if (ndone == 0) first_res = res;
                ndone++;
            end
            @(posedge clk); #1;
        end
        check("ign_ndone", ndone, 1);
        check("ign_res", first_res, 8'h02);

        // reset mid-CALC, after a result with ovf set
        run_op("prerst", 8'h64, 8'hE4, 8'h48, 1'b1);
        @(negedge clk);
        opA = 8'h05; opB = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_res", res, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk); rst = 1'b0;
        run_op("post", 8'h7F, 8'h01, 8'h7E, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
